// File: rtl/config_read_eng_pkg.sv
// config_read_eng_pkg: shared types and constants for the config-table readback responder.
//   Defines UDP metadata, machine tuple, response header layout, message types,
//   FSM state encoding and the reply-length helper.
package config_read_eng_pkg;

    localparam int NOC_DATA_W        = 512;
    localparam int NOC_PADBYTES      = NOC_DATA_W / 8;
    localparam int NOC_DATA_BYTES    = NOC_PADBYTES;
    localparam int NOC_PADBYTES_W    = $clog2(NOC_PADBYTES);
    localparam int CONFIG_NODE_CNT_W = 8;
    localparam int CONFIG_ADDR_W     = 8;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] data_length;
    } udp_info;

    typedef struct packed {
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] port;
    } machine_tuple;

    localparam int MACHINE_TUPLE_W     = $bits(machine_tuple);
    localparam int MACHINE_TUPLE_BYTES = MACHINE_TUPLE_W / 8;
    localparam int TUPLES_PER_FLIT     = NOC_DATA_W / MACHINE_TUPLE_W;
    localparam int FILL_W              = $clog2(TUPLES_PER_FLIT + 1);

    typedef enum logic [7:0] {
        GET_CONFIG_REQ  = 8'h20,
        GET_CONFIG_RESP = 8'h21
    } vr_msg_e;

    localparam logic [15:0] NONFRAG_MAGIC = 16'hFFFF;

    typedef struct packed {
        logic [15:0] frag_num;
        logic [7:0]  msg_type;
        logic [31:0] msg_len;
    } beehive_hdr;

    typedef struct packed {
        beehive_hdr                   hdr;
        logic [CONFIG_NODE_CNT_W-1:0] node_cnt;
    } cfg_resp_hdr;

    // Header occupies whole bytes at the top of the first flit; any rounding is zero fill.
    localparam int CFG_RESP_HDR_W     = (($bits(cfg_resp_hdr) + 7) / 8) * 8;
    localparam int CFG_RESP_HDR_BYTES = CFG_RESP_HDR_W / 8;
    localparam logic [NOC_PADBYTES_W-1:0] HDR_PADBYTES =
        NOC_PADBYTES_W'(NOC_DATA_BYTES - CFG_RESP_HDR_BYTES);

    typedef enum logic [2:0] {
        IDLE, DRAIN, META, HDR, RD_REQ, WAIT_RESP, SEND
    } cfgrd_state_e;

    function automatic logic [15:0] cfg_resp_len(input logic [CONFIG_NODE_CNT_W-1:0] cnt);
        return 16'(CFG_RESP_HDR_BYTES) + 16'(cnt) * 16'(MACHINE_TUPLE_BYTES);
    endfunction

endpackage

// File: rtl/config_read_eng_packer.sv
// cfg_tuple_packer: accumulates machine tuples MSB-first into one NoC flit.
//   clr_i clears buffer and fill, push_i writes tuple_i into slot fill;
//   flit_o is the buffer, fill_o the tuple count, padbytes_o the unused trailing bytes.
module cfg_tuple_packer
    import config_read_eng_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      push_i,
    input  machine_tuple              tuple_i,
    output logic [NOC_DATA_W-1:0]     flit_o,
    output logic [FILL_W-1:0]         fill_o,
    output logic [NOC_PADBYTES_W-1:0] padbytes_o
);
    logic [NOC_DATA_W-1:0] buf_q, buf_d, slot;
    logic [FILL_W-1:0]     fill_q, fill_d;
    // Tuple parked at the top of the flit, then shifted down to its slot.
    assign slot = {tuple_i, {(NOC_DATA_W - MACHINE_TUPLE_W){1'b0}}};
    always_comb begin
        buf_d  = clr_i ? '0 : push_i ? buf_q | (slot >> (fill_q * MACHINE_TUPLE_W)) : buf_q;
        fill_d = clr_i ? '0 : push_i ? fill_q + FILL_W'(1) : fill_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end
    assign flit_o     = buf_q;
    assign fill_o     = fill_q;
    assign padbytes_o = NOC_PADBYTES_W'(NOC_PADBYTES - int'(fill_q) * MACHINE_TUPLE_BYTES);
endmodule

// File: rtl/config_read_eng.sv
// config_read_eng: GetConfig responder that reads every machine tuple from the config table
//   and replies with one UDP message (header flit plus packed tuple flits).
//   Ports: request metadata/flits in (src_cfgrd_*), table read port (rd_machine_*),
//   reply metadata/flits out (cfgrd_to_udp_*), node_count and engine-idle flag.
module config_read_eng
    import config_read_eng_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         src_cfgrd_msg_val,
    input  udp_info                      src_cfgrd_pkt_info,
    output logic                         cfgrd_src_msg_rdy,
    input  logic                         src_cfgrd_req_val,
    input  logic                         src_cfgrd_req_last,
    output logic                         cfgrd_src_req_rdy,
    input  logic [CONFIG_NODE_CNT_W-1:0] node_count,
    output logic                         rd_machine_req_val,
    output logic [CONFIG_ADDR_W-1:0]     rd_machine_req_addr,
    input  logic                         rd_machine_req_rdy,
    input  logic                         rd_machine_resp_val,
    input  machine_tuple                 rd_machine_resp_data,
    output logic                         rd_machine_resp_rdy,
    output logic                         cfgrd_to_udp_meta_val,
    output udp_info                      cfgrd_to_udp_meta_info,
    input  logic                         to_udp_cfgrd_meta_rdy,
    output logic                         cfgrd_to_udp_data_val,
    output logic [NOC_DATA_W-1:0]        cfgrd_to_udp_data,
    output logic [NOC_PADBYTES_W-1:0]    cfgrd_to_udp_data_padbytes,
    output logic                         cfgrd_to_udp_data_last,
    input  logic                         to_udp_cfgrd_data_rdy,
    output logic                         cfgrd_eng_rdy
);
    cfgrd_state_e                 state_q, state_d;
    udp_info                      pkt_q, pkt_d;
    logic [CONFIG_NODE_CNT_W-1:0] cnt_q, cnt_d, rd_idx_q, rd_idx_d;
    logic                         clr, push;
    logic [NOC_DATA_W-1:0]        flit;
    logic [FILL_W-1:0]            fill;
    logic [NOC_PADBYTES_W-1:0]    pad;
    cfg_resp_hdr                  hdr;

    cfg_tuple_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr),
        .push_i    (push),
        .tuple_i   (rd_machine_resp_data),
        .flit_o    (flit),
        .fill_o    (fill),
        .padbytes_o(pad)
    );

    always_comb begin
        state_d               = state_q;
        pkt_d                 = pkt_q;
        cnt_d                 = cnt_q;
        rd_idx_d              = rd_idx_q;
        clr                   = 1'b0;
        push                  = 1'b0;
        cfgrd_src_msg_rdy     = 1'b0;
        cfgrd_eng_rdy         = 1'b0;
        cfgrd_src_req_rdy     = 1'b0;
        cfgrd_to_udp_meta_val = 1'b0;
        cfgrd_to_udp_data_val = 1'b0;
        rd_machine_req_val    = 1'b0;
        rd_machine_resp_rdy   = 1'b0;
        case (state_q)
            IDLE: begin
                cfgrd_src_msg_rdy = 1'b1;
                cfgrd_eng_rdy     = 1'b1;
                if (src_cfgrd_msg_val) begin
                    pkt_d    = src_cfgrd_pkt_info;
                    cnt_d    = node_count;
                    rd_idx_d = '0;
                    clr      = 1'b1;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                cfgrd_src_req_rdy = 1'b1;
                if (src_cfgrd_req_val && src_cfgrd_req_last) state_d = META;
            end
            META: begin
                cfgrd_to_udp_meta_val = 1'b1;
                if (to_udp_cfgrd_meta_rdy) state_d = HDR;
            end
            HDR: begin
                cfgrd_to_udp_data_val = 1'b1;
                if (to_udp_cfgrd_data_rdy) state_d = (cnt_q == '0) ? IDLE : RD_REQ;
            end
            RD_REQ: begin
                rd_machine_req_val = 1'b1;
                if (rd_machine_req_rdy) state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                rd_machine_resp_rdy = 1'b1;
                if (rd_machine_resp_val) begin
                    push     = 1'b1;
                    rd_idx_d = rd_idx_q + CONFIG_NODE_CNT_W'(1);
                    // Flush when this tuple fills the flit or is the last one in the table.
                    state_d  = (fill == FILL_W'(TUPLES_PER_FLIT - 1) || rd_idx_d == cnt_q) ? SEND : RD_REQ;
                end
            end
            SEND: begin
                cfgrd_to_udp_data_val = 1'b1;
                if (to_udp_cfgrd_data_rdy) begin
                    clr     = 1'b1;
                    state_d = (rd_idx_q == cnt_q) ? IDLE : RD_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pkt_q    <= '0;
            cnt_q    <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            cnt_q    <= cnt_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    assign hdr = '{hdr: '{frag_num: NONFRAG_MAGIC, msg_type: GET_CONFIG_RESP,
                          msg_len: 32'(cnt_q) * 32'(MACHINE_TUPLE_BYTES)},
                   node_cnt: cnt_q};

    assign cfgrd_to_udp_meta_info = '{src_ip: pkt_q.dst_ip, dst_ip: pkt_q.src_ip,
                                      src_port: pkt_q.dst_port, dst_port: pkt_q.src_port,
                                      data_length: cfg_resp_len(cnt_q)};

    assign rd_machine_req_addr        = CONFIG_ADDR_W'(rd_idx_q);
    assign cfgrd_to_udp_data          = (state_q == HDR) ? {hdr, {(NOC_DATA_W - $bits(cfg_resp_hdr)){1'b0}}} : flit;
    assign cfgrd_to_udp_data_padbytes = (state_q == HDR) ? HDR_PADBYTES : pad;
    assign cfgrd_to_udp_data_last     = (state_q == HDR) ? (cnt_q == '0) : (rd_idx_q == cnt_q);
endmodule

// File: tb/tb_config_read_eng.sv
// tb_config_read_eng: randomized self-checking bench for config_read_eng against a message-level model.
module tb_config_read_eng;
    import config_read_eng_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         rst_n;
    logic                         src_cfgrd_msg_val = 0;
    udp_info                      src_cfgrd_pkt_info = '0;
    logic                         cfgrd_src_msg_rdy;
    logic                         src_cfgrd_req_val = 0;
    logic                         src_cfgrd_req_last = 0;
    logic                         cfgrd_src_req_rdy;
    logic [CONFIG_NODE_CNT_W-1:0] node_count = '0;
    logic                         rd_machine_req_val;
    logic [CONFIG_ADDR_W-1:0]     rd_machine_req_addr;
    logic                         rd_machine_req_rdy = 0;
    logic                         rd_machine_resp_val = 0;
    machine_tuple                 rd_machine_resp_data = '0;
    logic                         rd_machine_resp_rdy;
    logic                         cfgrd_to_udp_meta_val;
    udp_info                      cfgrd_to_udp_meta_info;
    logic                         to_udp_cfgrd_meta_rdy = 0;
    logic                         cfgrd_to_udp_data_val;
    logic [NOC_DATA_W-1:0]        cfgrd_to_udp_data;
    logic [NOC_PADBYTES_W-1:0]    cfgrd_to_udp_data_padbytes;
    logic                         cfgrd_to_udp_data_last;
    logic                         to_udp_cfgrd_data_rdy = 0;
    logic                         cfgrd_eng_rdy;

    config_read_eng dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .src_cfgrd_msg_val         (src_cfgrd_msg_val),
        .src_cfgrd_pkt_info        (src_cfgrd_pkt_info),
        .cfgrd_src_msg_rdy         (cfgrd_src_msg_rdy),
        .src_cfgrd_req_val         (src_cfgrd_req_val),
        .src_cfgrd_req_last        (src_cfgrd_req_last),
        .cfgrd_src_req_rdy         (cfgrd_src_req_rdy),
        .node_count                (node_count),
        .rd_machine_req_val        (rd_machine_req_val),
        .rd_machine_req_addr       (rd_machine_req_addr),
        .rd_machine_req_rdy        (rd_machine_req_rdy),
        .rd_machine_resp_val       (rd_machine_resp_val),
        .rd_machine_resp_data      (rd_machine_resp_data),
        .rd_machine_resp_rdy       (rd_machine_resp_rdy),
        .cfgrd_to_udp_meta_val     (cfgrd_to_udp_meta_val),
        .cfgrd_to_udp_meta_info    (cfgrd_to_udp_meta_info),
        .to_udp_cfgrd_meta_rdy     (to_udp_cfgrd_meta_rdy),
        .cfgrd_to_udp_data_val     (cfgrd_to_udp_data_val),
        .cfgrd_to_udp_data         (cfgrd_to_udp_data),
        .cfgrd_to_udp_data_padbytes(cfgrd_to_udp_data_padbytes),
        .cfgrd_to_udp_data_last    (cfgrd_to_udp_data_last),
        .to_udp_cfgrd_data_rdy     (to_udp_cfgrd_data_rdy),
        .cfgrd_eng_rdy             (cfgrd_eng_rdy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [NOC_DATA_W-1:0] obs, input logic [NOC_DATA_W-1:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    machine_tuple          mem [256];
    udp_info               exp_meta;
    logic [NOC_DATA_W-1:0] exp_data [$];
    int                    exp_pad [$];
    bit                    exp_last [$];
    logic [7:0]            pending [$];
    int  rd_count, meta_seen, data_seen;
    bit  msg_pend, stall, hold, req_keep, resp_keep, meta_wait, data_wait;
    int  req_left;
    udp_info               meta_saved;
    logic [NOC_DATA_W-1:0] data_saved;
    logic [NOC_PADBYTES_W-1:0] pad_saved;
    logic                  last_saved;

    // Expected reply for cnt tuples: 8-byte header flit, then tuples 5 per flit, 12 bytes each.
    task automatic plan(input int cnt, input udp_info info);
        logic [NOC_DATA_W-1:0] f;
        int n;
        exp_meta = '{src_ip: info.dst_ip, dst_ip: info.src_ip, src_port: info.dst_port,
                     dst_port: info.src_port, data_length: 16'(8 + 12 * cnt)};
        exp_data.delete(); exp_pad.delete(); exp_last.delete();
        f = '0;
        f[511 -: 64] = {NONFRAG_MAGIC, 8'(GET_CONFIG_RESP), 32'(cnt * 12), 8'(cnt)};
        exp_data.push_back(f); exp_pad.push_back(56); exp_last.push_back(cnt == 0);
        for (int base = 0; base < cnt; base += 5) begin
            n = (cnt - base < 5) ? cnt - base : 5;
            f = '0;
            for (int k = 0; k < n; k++) f[511 - 96 * k -: 96] = mem[base + k];
            exp_data.push_back(f); exp_pad.push_back(64 - 12 * n); exp_last.push_back(base + n == cnt);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        src_cfgrd_msg_val = msg_pend;
        if (msg_pend && cfgrd_src_msg_rdy) msg_pend = 0;
        src_cfgrd_req_val  = (req_left > 0) && (req_keep || !stall || 1'($urandom_range(1)));
        src_cfgrd_req_last = (req_left == 1);
        if (src_cfgrd_req_val && cfgrd_src_req_rdy) begin
            req_left--;
            req_keep = 0;
        end else req_keep = src_cfgrd_req_val;
        rd_machine_req_rdy = !stall || 1'($urandom_range(1));
        if (rd_machine_req_val && rd_machine_req_rdy) begin
            check("rd_addr", rd_machine_req_addr, rd_count);
            rd_count++;
            pending.push_back(rd_machine_req_addr);
        end
        if (!resp_keep) begin
            rd_machine_resp_val = !hold && pending.size() > 0 && (!stall || 1'($urandom_range(1)));
            if (rd_machine_resp_val) rd_machine_resp_data = mem[pending[0]];
        end
        if (rd_machine_resp_val && rd_machine_resp_rdy) begin
            void'(pending.pop_front());
            resp_keep = 0;
        end else resp_keep = rd_machine_resp_val;
        if (meta_wait) begin
            check("meta_hold_val", cfgrd_to_udp_meta_val, 1);
            check("meta_hold_info", cfgrd_to_udp_meta_info, meta_saved);
        end
        to_udp_cfgrd_meta_rdy = !stall || 1'($urandom_range(1));
        if (cfgrd_to_udp_meta_val && to_udp_cfgrd_meta_rdy) begin
            check("meta_info", cfgrd_to_udp_meta_info, exp_meta);
            meta_seen++;
        end
        meta_wait  = cfgrd_to_udp_meta_val && !to_udp_cfgrd_meta_rdy;
        meta_saved = cfgrd_to_udp_meta_info;
        if (data_wait) begin
            check("data_hold_val", cfgrd_to_udp_data_val, 1);
            check("data_hold_flit", cfgrd_to_udp_data, data_saved);
            check("data_hold_pad", cfgrd_to_udp_data_padbytes, pad_saved);
            check("data_hold_last", cfgrd_to_udp_data_last, last_saved);
        end
        to_udp_cfgrd_data_rdy = !stall || 1'($urandom_range(1));
        if (cfgrd_to_udp_data_val && to_udp_cfgrd_data_rdy) begin
            if (data_seen < exp_data.size()) begin
                check("flit_data", cfgrd_to_udp_data, exp_data[data_seen]);
                check("flit_pad", cfgrd_to_udp_data_padbytes, exp_pad[data_seen]);
                check("flit_last", cfgrd_to_udp_data_last, exp_last[data_seen]);
            end else check("flit_extra", data_seen, exp_data.size());
            data_seen++;
        end
        data_wait  = cfgrd_to_udp_data_val && !to_udp_cfgrd_data_rdy;
        data_saved = cfgrd_to_udp_data;
        pad_saved  = cfgrd_to_udp_data_padbytes;
        last_saved = cfgrd_to_udp_data_last;
    endtask

    task automatic start_txn(input int cnt, input int nflits, input bit stl);
        udp_info info;
        info = '{src_ip: $urandom, dst_ip: $urandom, src_port: 16'($urandom),
                 dst_port: 16'($urandom), data_length: 16'($urandom)};
        plan(cnt, info);
        src_cfgrd_pkt_info = info;
        node_count = 8'(cnt);
        msg_pend = 1; req_left = nflits; stall = stl;
        rd_count = 0; meta_seen = 0; data_seen = 0;
    endtask

    task automatic run_txn(input int cnt, input int nflits, input bit stl, input bit chg);
        int n = 0;
        start_txn(cnt, nflits, stl);
        while (data_seen < exp_data.size() && n < 3000) begin
            tick();
            n++;
            if (chg && meta_seen > 0) node_count = 8'd2;
        end
        tick();
        tick();
        check("txn_timeout", n < 3000, 1);
        check("read_count", rd_count, cnt);
        check("flit_count", data_seen, exp_data.size());
        check("meta_count", meta_seen, 1);
        check("eng_rdy_after", cfgrd_eng_rdy, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_msg_rdy"}, cfgrd_src_msg_rdy, 1);
        check({tag, "_eng_rdy"}, cfgrd_eng_rdy, 1);
        check({tag, "_req_rdy"}, cfgrd_src_req_rdy, 0);
        check({tag, "_rd_val"}, rd_machine_req_val, 0);
        check({tag, "_resp_rdy"}, rd_machine_resp_rdy, 0);
        check({tag, "_meta_val"}, cfgrd_to_udp_meta_val, 0);
        check({tag, "_data_val"}, cfgrd_to_udp_data_val, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        run_txn(3, 1, 0, 0);
        run_txn(7, 1, 0, 0);
        run_txn(0, 1, 0, 0);
        run_txn(3, 3, 1, 1);
        run_txn(5, 2, 1, 0);
        run_txn(10, 1, 1, 0);
        for (int t = 0; t < 6; t++) run_txn($urandom_range(0, 12), $urandom_range(1, 3), 1'($urandom_range(1)), 0);
        hold = 1;
        start_txn(4, 1, 0);
        n = 0;
        while (!rd_machine_resp_rdy && n < 200) begin
            tick();
            n++;
        end
        check("reach_wait_resp", rd_machine_resp_rdy, 1);
        #2 rst_n = 0;
        #1 check_reset_outputs("mid_reset");
        hold = 0; meta_wait = 0; data_wait = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("late_resp_val", rd_machine_resp_val, 1);
            check("late_resp_rdy", rd_machine_resp_rdy, 0);
        end
        pending.delete();
        rd_machine_resp_val = 0;
        resp_keep = 0;
        run_txn(6, 2, 1, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/config_read_eng.md
Name: config_read_eng

Overview:
- Readback responder for the cluster configuration table that the VR setup path populates.
- Accepts a GetConfig request (UDP metadata plus request flits) and reads every machine tuple from the config table, one outstanding read at a time.
- Replies with one UDP message: a header flit, then tuples packed MSB-first into NOC_DATA_W flits.
- Sits beside the setup engine behind the VR UDP dispatch, and shares the config table's read port.

Parameters:
NOC_DATA_W, 512, NoC/UDP data flit width in bits
NOC_PADBYTES, NOC_DATA_W/8, flit width in bytes
NOC_PADBYTES_W, $clog2(NOC_PADBYTES), padbytes field width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
src_cfgrd_msg_val  in  1  request metadata valid
src_cfgrd_pkt_info  in  udp_info  request UDP metadata
cfgrd_src_msg_rdy  out  1  metadata ready
src_cfgrd_req_val  in  1  request flit valid
src_cfgrd_req_last  in  1  last request flit
cfgrd_src_req_rdy  out  1  request flit ready (request payload is ignored and drained)
node_count  in  CONFIG_NODE_CNT_W  current configured node count
rd_machine_req_val  out  1  table read request valid
rd_machine_req_addr  out  CONFIG_ADDR_W  table index
rd_machine_req_rdy  in  1  table read request accepted
rd_machine_resp_val  in  1  read data valid
rd_machine_resp_data  in  machine_tuple  read data
rd_machine_resp_rdy  out  1  read data ready
cfgrd_to_udp_meta_val  out  1  reply metadata valid
cfgrd_to_udp_meta_info  out  udp_info  reply metadata
to_udp_cfgrd_meta_rdy  in  1  reply metadata ready
cfgrd_to_udp_data_val  out  1  reply flit valid
cfgrd_to_udp_data  out  NOC_DATA_W  reply flit
cfgrd_to_udp_data_padbytes  out  NOC_PADBYTES_W  unused trailing bytes
cfgrd_to_udp_data_last  out  1  last reply flit
cfgrd_eng_rdy  out  1  engine idle

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE and counters clear.
  - All val and rdy outputs are 0, except cfgrd_src_msg_rdy=1 and cfgrd_eng_rdy=1.
  - Reset mid-operation abandons the reply with no further flits; any in-flight read response is dropped when it arrives (resp_rdy is asserted only in WAIT_RESP).
- Handshakes are val/rdy; a transfer occurs when both are high on a rising clk. Valid outputs must stay stable until accepted.
- IDLE: msg_rdy=1 and eng_rdy=1. On msg_val:
  - latch pkt_info;
  - latch node_count into cnt_reg, frozen for the whole transaction;
  - clear rd_idx and fill;
  - go to DRAIN.
- DRAIN: req_rdy=1. On req_val && req_last go to META; non-last flits are discarded.
- META: meta_val=1. meta_info is the latched info with src/dst IP and src/dst port swapped, and data_length = CFG_RESP_HDR_BYTES + cnt_reg*MACHINE_TUPLE_BYTES. Computed at 16 bits, no overflow for legal counts. On meta_rdy go to HDR.
- HDR: data_val=1 with the flit = {cfg_resp_hdr, zeros}.
  - hdr.frag_num=NONFRAG_MAGIC, msg_type=GetConfigResp, msg_len=cnt_reg*MACHINE_TUPLE_BYTES, node_cnt=cnt_reg.
  - padbytes = NOC_DATA_BYTES - CFG_RESP_HDR_BYTES; last=(cnt_reg==0).
  - On data_rdy: go to IDLE if cnt_reg==0, else RD_REQ.
- RD_REQ: req_val=1, addr=rd_idx. On req_rdy go to WAIT_RESP.
- WAIT_RESP: resp_rdy=1. On resp_val:
  - shift the tuple into flit_buf at slot `fill`, MSB-first: slot 0 occupies the top MACHINE_TUPLE_W bits;
  - rd_idx++ and fill++;
  - if fill+1==TUPLES_PER_FLIT or rd_idx+1==cnt_reg go to SEND, else RD_REQ.
- SEND: data_val=1, data=flit_buf with the unused low bits zero.
  - padbytes = NOC_DATA_BYTES - fill*MACHINE_TUPLE_BYTES.
  - last = (rd_idx==cnt_reg).
  - On data_rdy: clear fill and flit_buf; go to IDLE if last, else RD_REQ.
- Table changes during a transaction are not guarded. Tuples read after a concurrent setup write reflect the new values; the count stays cnt_reg.
- Minimum latency from meta accept to first data flit: 1 cycle.

Decomposition:
- Add to beehive_vr_pkg:
  - GetConfigReq and GetConfigResp msg_type values;
  - struct cfg_resp_hdr {beehive_hdr hdr; logic [CONFIG_NODE_CNT_W-1:0] node_cnt} padded to whole bytes;
  - CFG_RESP_HDR_W and CFG_RESP_HDR_BYTES;
  - MACHINE_TUPLE_BYTES;
  - TUPLES_PER_FLIT = NOC_DATA_W/MACHINE_TUPLE_W.
- Natural sub-module: cfg_tuple_packer, which holds flit_buf, fill and the padbytes computation (shift-in and clear).

Test Plan:
Bench uses MACHINE_TUPLE_W=96 (12 B), so TUPLES_PER_FLIT=5, and CFG_RESP_HDR_BYTES=8.
- node_count=3, tuples A,B,C -> meta data_length=44 with IPs/ports swapped. Header flit padbytes 56, last=0. One data flit {A,B,C,0}, padbytes 28, last=1. Exactly 3 reads at addr 0,1,2.
- node_count=7 -> flit1 holds 5 tuples, padbytes 4, last=0. Flit2 holds 2 tuples, padbytes 40, last=1. data_length=92.
- node_count=0 -> no reads. Single header flit, last=1, data_length=8. Back to IDLE with eng_rdy=1.
- 3-flit request, random rd_req_rdy/resp_val/data_rdy stalls -> payload unchanged and held stable while val&&!rdy. node_count changed mid-transaction to 2 from 3 -> still 3 tuples sent.
- rst_n pulsed low while in WAIT_RESP -> outputs immediately at reset values. A late resp_val is not accepted. The next request completes correctly.
